// File: rtl/systolic_tile_sequencer.sv
// Tile-pass sequencer for the systolic GEMM datapath: weight load, activation
// streaming, fixed-latency valid tracking and completion handshake.
module systolic_tile_sequencer #(
    parameter int PORTS    = 8,
    parameter int ROW_W    = 8,
    parameter int PIPE_LAT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     reuse_weights,
    input  logic [ROW_W-1:0]         num_rows,
    output logic                     w_load_en,
    output logic [$clog2(PORTS)-1:0] w_row_idx,
    output logic                     a_rd_en,
    output logic [ROW_W-1:0]         a_rd_addr,
    output logic                     out_valid,
    output logic [ROW_W-1:0]         out_wr_addr,
    output logic                     busy,
    output logic                     done
);
    localparam int IDX_W = $clog2(PORTS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [ROW_W-1:0] LAST_W = ROW_W'(PORTS - 1);

    logic [2:0]          state_q, state_d;
    logic [ROW_W-1:0]    rows_q, rows_d;
    logic [ROW_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [ROW_W-1:0]    out_addr_q, out_addr_d;
    logic [PIPE_LAT-1:0] sr_q, sr_d;
    logic [PIPE_LAT:0]   sr_shift;
    logic                w_load_en_q, a_rd_en_q, busy_q, done_q;

    assign cnt_inc  = cnt_q + ROW_W'(1);
    assign sr_shift = {sr_q, a_rd_en_q};
    assign sr_d     = sr_shift[PIPE_LAT-1:0];

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d = num_rows;
                    cnt_d  = '0;
                    if (!reuse_weights)
                        state_d = S_LOAD_W;
                    else if (num_rows != '0)
                        state_d = S_STREAM;
                    else
                        state_d = S_DONE;
                end
            end
            S_LOAD_W: begin
                if (cnt_q == LAST_W) begin
                    cnt_d   = '0;
                    state_d = (rows_q != '0) ? S_STREAM : S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_STREAM: begin
                if (cnt_inc == rows_q) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DRAIN: begin
                // Leave while the last valid is at the tail so DONE follows it directly.
                if (sr_d == '0)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_addr_d = out_addr_q;
        if (out_valid)
            out_addr_d = out_addr_q + ROW_W'(1);
        else if (state_q == S_DONE)
            out_addr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            cnt_q       <= '0;
            sr_q        <= '0;
            out_addr_q  <= '0;
            w_load_en_q <= 1'b0;
            a_rd_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            out_addr_q  <= out_addr_d;
            w_load_en_q <= (state_d == S_LOAD_W);
            a_rd_en_q   <= (state_d == S_STREAM);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
        end
    end

    // The shared counter is zero outside LOAD_W/STREAM, so idle addresses read 0.
    assign w_load_en   = w_load_en_q;
    assign w_row_idx   = cnt_q[IDX_W-1:0];
    assign a_rd_en     = a_rd_en_q;
    assign a_rd_addr   = cnt_q;
    assign out_valid   = sr_q[PIPE_LAT-1];
    assign out_wr_addr = out_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Scoreboard bench for systolic_tile_sequencer with PORTS=4, PIPE_LAT=8.
module tb_systolic_tile_sequencer;
    localparam int P = 4;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst, start, reuse_weights;
    logic [7:0] num_rows;
    logic       w_load_en, a_rd_en, out_valid, busy, done;
    logic [1:0] w_row_idx;
    logic [7:0] a_rd_addr, out_wr_addr;

    systolic_tile_sequencer #(.PORTS(P), .ROW_W(8), .PIPE_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_weights(reuse_weights),
        .num_rows(num_rows), .w_load_en(w_load_en), .w_row_idx(w_row_idx),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .out_valid(out_valid),
        .out_wr_addr(out_wr_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int val; } ev_t;
    ev_t qw[$];
    ev_t qa[$];
    ev_t qo[$];
    int  qd[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int t0;
    bit mon_en = 1'b0;
    ev_t e;
    int  dc;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expected events whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (w_load_en) begin
                if (qw.size() == 0) check("w_load_unexpected", 1, 0);
                else begin
                    e = qw.pop_front();
                    check("w_load_cycle", cyc, e.cyc);
                    check("w_row_idx", int'(w_row_idx), e.val);
                end
            end
            if (a_rd_en) begin
                if (qa.size() == 0) check("a_rd_unexpected", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_rd_cycle", cyc, e.cyc);
                    check("a_rd_addr", int'(a_rd_addr), e.val);
                end
            end
            if (out_valid) begin
                if (qo.size() == 0) check("out_valid_unexpected", 1, 0);
                else begin
                    e = qo.pop_front();
                    check("out_valid_cycle", cyc, e.cyc);
                    check("out_wr_addr", int'(out_wr_addr), e.val);
                end
            end
            if (done) begin
                if (qd.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    dc = qd.pop_front();
                    check("done_cycle", cyc, dc);
                end
            end
            check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_w_load_en"}, int'(w_load_en), 0);
        check({tag, "_w_row_idx"}, int'(w_row_idx), 0);
        check({tag, "_a_rd_en"}, int'(a_rd_en), 0);
        check({tag, "_a_rd_addr"}, int'(a_rd_addr), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_wr_addr"}, int'(out_wr_addr), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Issues start in the current cycle (cycle 0) and steps to the cycle after done.
    // done_off is the hand-computed done cycle; p1/p2 are extra start pulses to be ignored.
    task automatic run_pass(input int r, input bit ru, input int done_off,
                            input int p1, input int p2);
        int s;
        int b;
        start = 1'b1;
        reuse_weights = ru;
        num_rows = 8'(r);
        b = cyc;
        s = ru ? 1 : P + 1;
        if (!ru)
            for (int i = 0; i < P; i++) qw.push_back(ev_t'{b + 1 + i, i});
        for (int i = 0; i < r; i++) begin
            qa.push_back(ev_t'{b + s + i, i});
            qo.push_back(ev_t'{b + s + i + L, i});
        end
        qd.push_back(b + done_off);
        busy_lo = b + 1;
        busy_hi = b + done_off;
        for (int k = 1; k <= done_off + 1; k++) begin
            @(negedge clk);
            start = (k == p1 || k == p2);
            if (start) begin
                num_rows = 8'd7;
                reuse_weights = ~ru;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        reuse_weights = 1'b0;
        num_rows = 8'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        run_pass(3, 1'b0, 16, -1, -1);   // full pass
        run_pass(3, 1'b1, 12, -1, -1);   // weight reuse
        run_pass(0, 1'b1, 1, -1, -1);    // zero rows, reuse
        run_pass(0, 1'b0, 5, -1, -1);    // zero rows, load
        run_pass(3, 1'b0, 16, 6, 16);    // start while busy and in done cycle

        // Reset in cycle 10 of a full pass: only the load and reads before it occur.
        start = 1'b1;
        reuse_weights = 1'b0;
        num_rows = 8'd3;
        t0 = cyc;
        for (int i = 0; i < P; i++) qw.push_back(ev_t'{t0 + 1 + i, i});
        for (int i = 0; i < 3; i++) qa.push_back(ev_t'{t0 + 5 + i, i});
        busy_lo = t0 + 1;
        busy_hi = t0 + 10;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_pass(2, 1'b1, 11, -1, -1);   // fresh pass after abort

        run_pass(255, 1'b0, 268, -1, -1); // max count
        run_pass(2, 1'b1, 11, -1, -1);    // immediately following pass

        repeat (20) @(negedge clk);
        check("w_events_left", qw.size(), 0);
        check("a_events_left", qa.size(), 0);
        check("out_events_left", qo.size(), 0);
        check("done_events_left", qd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
